isp_cfg_sequencer: RTL and testbench

Frame-synchronous configuration controller for the ISP pipeline. A host writes stage enables and tuning parameters into a shadow register bank at any time, then requests a commit. The block copies the whole shadow bank into the active bank in one cycle at the next frame start (rising edge of `in_vsync`), so every frame is processed with one consistent parameter set. It sits between the host bus bridge and the pipeline enable and parameter inputs, and also maintains a frame counter.

---
 rtl/isp_cfg_pkg.sv | 50 +++++
 rtl/isp_vsync_edge.sv | 25 ++
 rtl/isp_cfg_sequencer.sv | 129 ++++++++++++
 tb/tb_isp_cfg_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_cfg_pkg.sv
// Shared constants for the ISP configuration sequencer:
// register map, enable bits, reset defaults and FSM states.
package isp_cfg_pkg;

  localparam int CFG_NREGS   = 16;

  localparam int REG_EN      = 0;
  localparam int REG_DPC_TH  = 1;
  localparam int REG_BLC_R   = 2;
  localparam int REG_BLC_GR  = 3;
  localparam int REG_BLC_GB  = 4;
  localparam int REG_BLC_B   = 5;
  localparam int REG_NR_LVL  = 6;
  localparam int REG_DG_GAIN = 7;
  localparam int REG_DG_OFF  = 8;
  localparam int REG_WB_R    = 9;
  localparam int REG_WB_G    = 10;
  localparam int REG_WB_B    = 11;

  localparam int EN_DPC      = 0;
  localparam int EN_BLC      = 1;
  localparam int EN_BNR      = 2;
  localparam int EN_DGAIN    = 3;
  localparam int EN_DEMOSIC  = 4;
  localparam int EN_WB       = 5;
  localparam int EN_CCM      = 6;
  localparam int EN_CSC      = 7;
  localparam int EN_GAMMA    = 8;
  localparam int EN_NR2D     = 9;
  localparam int EN_EE       = 10;
  localparam int EN_STAT_AE  = 11;
  localparam int EN_STAT_AWB = 12;

  // Gains reset to 1.0 in Q4.4
  localparam logic [15:0] GAIN_ONE = 16'h0010;

  localparam logic [15:0] CFG_DEFAULTS [CFG_NREGS] = '{
    16'h0000, 16'h0000, 16'h0000, 16'h0000,
    16'h0000, 16'h0000, 16'h0000, GAIN_ONE,
    16'h0000, GAIN_ONE, GAIN_ONE, GAIN_ONE,
    16'h0000, 16'h0000, 16'h0000, 16'h0000
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    APPLY = 2'd2
  } cfg_state_t;

endpackage

// File: rtl/isp_vsync_edge.sv
// Two-flop vsync rising-edge detector; an input already high
// when reset releases is reported as a rise.
module isp_vsync_edge (
  input  logic pclk,
  input  logic rst,
  input  logic in_vsync,
  output logic rise
);

  logic vs_q;
  logic vs_q2;

  always_ff @(posedge pclk) begin
    if (rst) begin
      vs_q  <= 1'b0;
      vs_q2 <= 1'b0;
    end else begin
      vs_q  <= in_vsync;
      vs_q2 <= vs_q;
    end
  end

  assign rise = vs_q & ~vs_q2;

endmodule

// File: rtl/isp_cfg_sequencer.sv
// Shadow/active config bank with frame-synchronous commit.
// Optional forced apply on timeout: define ISP_CFG_TIMEOUT_EN.
module isp_cfg_sequencer
  import isp_cfg_pkg::*;
#(
  parameter int DATA_BITS      = 16,
  parameter int NREGS          = 16,
  parameter int ADDR_BITS      = 5,
  parameter int TIMEOUT_CYCLES = 1 << 20
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic                       in_vsync,
  input  logic                       cfg_wr,
  input  logic                       cfg_rd,
  input  logic [ADDR_BITS-1:0]       cfg_addr,
  input  logic [DATA_BITS-1:0]       cfg_wdata,
  output logic [DATA_BITS-1:0]       cfg_rdata,
  output logic                       cfg_ack,
  input  logic                       commit_req,
  output logic                       commit_busy,
  output logic                       commit_done,
  output logic [NREGS*DATA_BITS-1:0] act_regs,
  output logic [15:0]                frame_cnt,
  output logic                       timeout_err
);

  localparam int IDX_BITS = $clog2(NREGS);

  logic [DATA_BITS-1:0] shadow [NREGS];
  logic [DATA_BITS-1:0] act    [NREGS];
  cfg_state_t           state;
  logic                 rise;
  logic [IDX_BITS-1:0]  idx;
  logic                 act_sel;

  assign idx     = cfg_addr[IDX_BITS-1:0];
  assign act_sel = cfg_addr[ADDR_BITS-1];

  isp_vsync_edge u_edge (
    .pclk     (pclk),
    .rst      (rst),
    .in_vsync (in_vsync),
    .rise     (rise)
  );

`ifdef ISP_CFG_TIMEOUT_EN
  logic [23:0] to_cnt;
  logic        to_hit;

  assign to_hit = (to_cnt == 24'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge pclk) begin
    if (rst) begin
      state       <= IDLE;
      commit_done <= 1'b0;
      cfg_ack     <= 1'b0;
      cfg_rdata   <= '0;
      frame_cnt   <= '0;
`ifdef ISP_CFG_TIMEOUT_EN
      to_cnt      <= '0;
      timeout_err <= 1'b0;
`endif
      for (int i = 0; i < NREGS; i++) begin
        shadow[i] <= DATA_BITS'(CFG_DEFAULTS[i]);
        act[i]    <= DATA_BITS'(CFG_DEFAULTS[i]);
      end
    end else begin
      cfg_ack     <= cfg_wr | cfg_rd;
      cfg_rdata   <= '0;
      commit_done <= 1'b0;

      // Active-bank writes are acked but dropped
      if (cfg_wr) begin
        if (!act_sel) shadow[idx] <= cfg_wdata;
      end else if (cfg_rd) begin
        cfg_rdata <= act_sel ? act[idx] : shadow[idx];
      end

      if (rise) frame_cnt <= frame_cnt + 16'd1;

      unique case (state)
        IDLE: begin
          if (commit_req) begin
            state <= ARMED;
`ifdef ISP_CFG_TIMEOUT_EN
            to_cnt      <= '0;
            timeout_err <= 1'b0;
`endif
          end
        end
        ARMED: begin
          if (rise) begin
            state <= APPLY;
`ifdef ISP_CFG_TIMEOUT_EN
          end else if (to_hit) begin
            state       <= APPLY;
            timeout_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 24'd1;
`endif
          end
        end
        APPLY: begin
          // Copy sees pre-write shadow values of this cycle
          for (int i = 0; i < NREGS; i++) act[i] <= shadow[i];
          commit_done <= 1'b1;
          state       <= commit_req ? ARMED : IDLE;
`ifdef ISP_CFG_TIMEOUT_EN
          to_cnt      <= '0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef ISP_CFG_TIMEOUT_EN
  assign timeout_err = 1'b0;
`endif

  assign commit_busy = (state == ARMED);

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign act_regs[g*DATA_BITS +: DATA_BITS] = act[g];
  end

endmodule

// File: tb/tb_isp_cfg_sequencer.sv
// Self-checking bench for isp_cfg_sequencer: vector table,
// hand-written commit sequences and randomized host traffic.
module tb_isp_cfg_sequencer;

  logic         pclk = 1'b0;
  logic         rst;
  logic         in_vsync;
  logic         cfg_wr;
  logic         cfg_rd;
  logic [4:0]   cfg_addr;
  logic [15:0]  cfg_wdata;
  logic [15:0]  cfg_rdata;
  logic         cfg_ack;
  logic         commit_req;
  logic         commit_busy;
  logic         commit_done;
  logic [255:0] act_regs;
  logic [15:0]  frame_cnt;
  logic         timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 pclk = ~pclk;

  isp_cfg_sequencer #(
    .DATA_BITS      (16),
    .NREGS          (16),
    .ADDR_BITS      (5),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .pclk        (pclk),
    .rst         (rst),
    .in_vsync    (in_vsync),
    .cfg_wr      (cfg_wr),
    .cfg_rd      (cfg_rd),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_rdata   (cfg_rdata),
    .cfg_ack     (cfg_ack),
    .commit_req  (commit_req),
    .commit_busy (commit_busy),
    .commit_done (commit_done),
    .act_regs    (act_regs),
    .frame_cnt   (frame_cnt),
    .timeout_err (timeout_err)
  );

  typedef struct {
    logic        wr;
    logic        rd;
    logic [4:0]  addr;
    logic [15:0] wdata;
    logic        exp_ack;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [15];

  logic [15:0] msh [16];
  logic [15:0] mac [16];
  int          mframe;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [255:0] got,
                     input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] def_val(input int i);
    return (i == 7 || i == 9 || i == 10 || i == 11) ? 16'h0010 : 16'h0000;
  endfunction

  function automatic logic [255:0] pack_model();
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = mac[i];
    return v;
  endfunction

  function automatic logic [15:0] act_reg(input int i);
    return act_regs[i*16 +: 16];
  endfunction

  task automatic do_reset();
    rst        = 1'b1;
    in_vsync   = 1'b0;
    cfg_wr     = 1'b0;
    cfg_rd     = 1'b0;
    cfg_addr   = '0;
    cfg_wdata  = '0;
    commit_req = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      msh[i] = def_val(i);
      mac[i] = def_val(i);
    end
    mframe = 0;
  endtask

  task automatic host(input logic wr, input logic rd,
                      input logic [4:0] a, input logic [15:0] d);
    cfg_wr    = wr;
    cfg_rd    = rd;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_wr = 1'b0;
    cfg_rd = 1'b0;
  endtask

  task automatic pulse_commit();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
  endtask

  task automatic rand_commit();
    int dones;
    dones = 0;
    pulse_commit();
    tick();
    in_vsync = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (commit_done) dones++;
    end
    in_vsync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (commit_done) dones++;
    end
    mframe++;
    for (int i = 0; i < 16; i++) mac[i] = msh[i];
    chk("rnd_done_count", 256'(dones), 256'd1);
    chk("rnd_act_regs", act_regs, pack_model());
    chk("rnd_frame_cnt", 256'(frame_cnt), 256'(mframe[15:0]));
  endtask

  initial begin
    int          dones;
    int          j;
    logic [4:0]  a;
    logic [15:0] d;
    logic        both;
    logic [255:0] defv;

    vecs[0]  = '{1'b0, 1'b1, 5'd7,  16'h0000, 1'b1, 16'h0010};
    vecs[1]  = '{1'b0, 1'b1, 5'd23, 16'h0000, 1'b1, 16'h0010};
    vecs[2]  = '{1'b0, 1'b1, 5'd0,  16'h0000, 1'b1, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 5'd16, 16'h0000, 1'b1, 16'h0000};
    vecs[4]  = '{1'b1, 1'b1, 5'd2,  16'h00AA, 1'b1, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 5'd2,  16'h0000, 1'b1, 16'h00AA};
    vecs[6]  = '{1'b0, 1'b1, 5'd18, 16'h0000, 1'b1, 16'h0000};
    vecs[7]  = '{1'b1, 1'b0, 5'd18, 16'hBEEF, 1'b1, 16'h0000};
    vecs[8]  = '{1'b0, 1'b1, 5'd18, 16'h0000, 1'b1, 16'h0000};
    vecs[9]  = '{1'b0, 1'b1, 5'd2,  16'h0000, 1'b1, 16'h00AA};
    vecs[10] = '{1'b0, 1'b0, 5'd2,  16'h0000, 1'b0, 16'h0000};
    vecs[11] = '{1'b1, 1'b0, 5'd12, 16'h1234, 1'b1, 16'h0000};
    vecs[12] = '{1'b0, 1'b1, 5'd12, 16'h0000, 1'b1, 16'h1234};
    vecs[13] = '{1'b0, 1'b1, 5'd28, 16'h0000, 1'b1, 16'h0000};
    vecs[14] = '{1'b0, 1'b1, 5'd25, 16'h0000, 1'b1, 16'h0010};

    do_reset();
    for (int i = 0; i < 16; i++) defv[i*16 +: 16] = def_val(i);
    chk("rst_act_regs", act_regs, defv);
    chk("rst_act_reg0", 256'(act_reg(0)), 256'd0);
    chk("rst_frame_cnt", 256'(frame_cnt), 256'd0);
    chk("rst_busy", 256'(commit_busy), 256'd0);
    chk("rst_done", 256'(commit_done), 256'd0);
    chk("rst_ack", 256'(cfg_ack), 256'd0);
    chk("rst_timeout_err", 256'(timeout_err), 256'd0);

    for (int i = 0; i < 15; i++) begin
      host(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d_ack", i), 256'(cfg_ack), 256'(vecs[i].exp_ack));
      chk($sformatf("vec%0d_rdata", i), 256'(cfg_rdata),
          256'(vecs[i].exp_rdata));
    end
    tick();
    chk("single_ack_after_dual", 256'(cfg_ack), 256'd0);

    // Normal commit with exact apply latency
    host(1'b1, 1'b0, 5'd0, 16'h1FFF);
    pulse_commit();
    chk("nc_busy_armed", 256'(commit_busy), 256'd1);
    tick();
    tick();
    in_vsync = 1'b1;
    tick();
    chk("nc_done_k", 256'(commit_done), 256'd0);
    tick();
    chk("nc_frame_k1", 256'(frame_cnt), 256'd1);
    chk("nc_act_k1", 256'(act_reg(0)), 256'd0);
    tick();
    chk("nc_act_k2", 256'(act_reg(0) & 16'h1FFF), 256'h1FFF);
    chk("nc_done_k2", 256'(commit_done), 256'd1);
    chk("nc_busy_k2", 256'(commit_busy), 256'd0);
    chk("nc_frame_k2", 256'(frame_cnt), 256'd1);
    chk("nc_blc_gr_kept", 256'(act_reg(3)), 256'd0);
    chk("nc_blc_r", 256'(act_reg(2)), 256'h00AA);
    tick();
    chk("nc_done_k3", 256'(commit_done), 256'd0);
    in_vsync = 1'b0;
    tick();
    tick();

    // Write landing in the APPLY cycle
    pulse_commit();
    in_vsync = 1'b1;
    tick();
    tick();
    host(1'b1, 1'b0, 5'd9, 16'h0020);
    chk("wda_act_reg9_old", 256'(act_reg(9)), 256'h0010);
    chk("wda_done", 256'(commit_done), 256'd1);
    in_vsync = 1'b0;
    host(1'b0, 1'b1, 5'd9, 16'h0000);
    chk("wda_shadow9", 256'(cfg_rdata), 256'h0020);
    host(1'b0, 1'b1, 5'd25, 16'h0000);
    chk("wda_active9", 256'(cfg_rdata), 256'h0010);
    pulse_commit();
    in_vsync = 1'b1;
    tick();
    tick();
    tick();
    chk("wda_act_reg9_new", 256'(act_reg(9)), 256'h0020);
    in_vsync = 1'b0;
    tick();
    tick();
    chk("wda_frame_cnt", 256'(frame_cnt), 256'd3);

`ifdef ISP_CFG_TIMEOUT_EN
    pulse_commit();
    chk("to_err_clear0", 256'(timeout_err), 256'd0);
    j = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (commit_done) begin
        j = k;
        break;
      end
    end
    chk("to_apply_cycles", 256'(j), 256'd65);
    chk("to_err_set", 256'(timeout_err), 256'd1);
    pulse_commit();
    chk("to_err_cleared", 256'(timeout_err), 256'd0);
`else
    pulse_commit();
    for (int k = 0; k < 100; k++) tick();
    chk("noto_busy_held", 256'(commit_busy), 256'd1);
    chk("noto_err", 256'(timeout_err), 256'd0);
    chk("noto_act_reg9", 256'(act_reg(9)), 256'h0020);
`endif

    // Reset while armed drops the pending commit
    pulse_commit();
    host(1'b1, 1'b0, 5'd1, 16'h0033);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mar_busy", 256'(commit_busy), 256'd0);
    chk("mar_act_reg1", 256'(act_reg(1)), 256'd0);
    chk("mar_act_reg9", 256'(act_reg(9)), 256'h0010);
    chk("mar_frame", 256'(frame_cnt), 256'd0);
    in_vsync = 1'b1;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (commit_done) dones++;
    end
    in_vsync = 1'b0;
    chk("mar_no_done", 256'(dones), 256'd0);
    chk("mar_frame_after", 256'(frame_cnt), 256'd1);
    chk("mar_act_reg1_after", 256'(act_reg(1)), 256'd0);
    host(1'b0, 1'b1, 5'd1, 16'h0000);
    chk("mar_shadow1", 256'(cfg_rdata), 256'd0);

    // Randomized host traffic against a bank model
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int op;
      op = $urandom_range(0, 9);
      a  = 5'($urandom_range(0, 31));
      d  = 16'($urandom);
      if (op <= 4) begin
        both = ($urandom_range(0, 2) == 0);
        host(1'b1, both, a, d);
        if (!a[4]) msh[a[3:0]] = d;
        chk("rnd_wr_ack", 256'(cfg_ack), 256'd1);
        chk("rnd_wr_rdata", 256'(cfg_rdata), 256'd0);
      end else if (op <= 8) begin
        host(1'b0, 1'b1, a, 16'h0000);
        chk("rnd_rd_ack", 256'(cfg_ack), 256'd1);
        chk($sformatf("rnd_rd_a%0d", a), 256'(cfg_rdata),
            256'(a[4] ? mac[a[3:0]] : msh[a[3:0]]));
      end else begin
        rand_commit();
      end
    end
    rand_commit();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
